// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: received-frame stream from the SPI slave receiver.
//   data_o      - last good frame, bit 0 = first bit received
//   valid_o     - data_o holds an unconsumed frame
//   ready_i     - consumer accepts data_o when valid_o & ready_i
//   frame_err_o - one-cycle pulse, frame ended with wrong bit count
//   overrun_o   - one-cycle pulse, good frame dropped (previous unconsumed)
// modport master: the receiver side; modport slave: the consumer side.
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 96
);
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  frame_err_o;
  logic                  overrun_o;

  modport master (output data_o, valid_o, frame_err_o, overrun_o, input ready_i);
  modport slave  (input data_o, valid_o, frame_err_o, overrun_o, output ready_i);
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver (mode 0, LSB first), oversampled in clk.
//   clk, rst          - system clock (>= 4x sclk), synchronous active-high reset
//   sclk, ss_n, mosi  - async SPI inputs from the master
//   miso              - serial response; driven only with SPI_SLAVE_RX_MISO_EN
//   tx_data_i         - response word, loaded on frame start (SPI_SLAVE_RX_MISO_EN)
//   rx                - frame stream (data/valid/ready/frame_err/overrun)
// Optional feature macro: SPI_SLAVE_RX_MISO_EN (default: miso tied low).
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 96,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  spi_slave_rx_if.master        rx
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t state_q, state_d;

  // Synchronizers; MSB is the last stage. Presets match the idle bus.
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s, sclk_rise;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!ss_s) state_d = RECV;
      RECV:    if (ss_s)  state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic enter_recv;
  assign enter_recv = (state_q == IDLE) && !ss_s;

  // Receive datapath and output port
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  too_long;
  logic                  good;
  assign good = (cnt == CNT_MAX) && !too_long;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      shreg          <= '0;
      too_long       <= 1'b0;
      rx.data_o      <= '0;
      rx.valid_o     <= 1'b0;
      rx.frame_err_o <= 1'b0;
      rx.overrun_o   <= 1'b0;
    end else begin
      rx.frame_err_o <= 1'b0;
      rx.overrun_o   <= 1'b0;
      if (enter_recv) begin
        cnt      <= '0;
        shreg    <= '0;
        too_long <= 1'b0;
      end else if (state_q == RECV && sclk_rise) begin
        // shreg is cleared on entry, so OR-ing the bit in is enough
        if (cnt < CNT_MAX) begin
          shreg <= shreg | (DATA_WIDTH'(mosi_s) << cnt);
          cnt   <= cnt + 1'b1;
        end else begin
          too_long <= 1'b1;
        end
      end
      if (rx.valid_o && rx.ready_i) rx.valid_o <= 1'b0;
      // A CHECK load overrides the accept-clear above in the same cycle
      if (state_q == CHECK) begin
        if (good) begin
          if (!rx.valid_o || rx.ready_i) begin
            rx.data_o  <= shreg;
            rx.valid_o <= 1'b1;
          end else begin
            rx.overrun_o <= 1'b1;
          end
        end else begin
          rx.frame_err_o <= 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_RX_MISO_EN
  logic [DATA_WIDTH-1:0] txreg, txshift;
  logic [CW-1:0]         tx_idx;
  logic                  sclk_fall;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign txshift   = txreg >> tx_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      txreg  <= '0;
      tx_idx <= '0;
    end else if (enter_recv) begin
      txreg  <= tx_data_i;
      tx_idx <= '0;
    end else if (state_q == RECV && sclk_fall && tx_idx < CNT_MAX) begin
      tx_idx <= tx_idx + 1'b1;
    end
  end

  // Low outside RECV and once all DATA_WIDTH bits have been shifted out
  assign miso = (state_q == RECV && tx_idx < CNT_MAX) ? txshift[0] : 1'b0;
`else
  logic unused_tx;
  assign unused_tx = ^tx_data_i;
  assign miso      = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;
  localparam int DW = 96;
  localparam int K_DATA = 1, K_ERR = 2, K_OVR = 3;

  logic clk = 1'b0, rst, sclk, ss_n, mosi, miso;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] miso_cap;

  spi_slave_rx_if #(.DATA_WIDTH(DW)) rx ();

  spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .tx_data_i(tx_data), .rx(rx.master)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [DW-1:0] data; } exp_t;
  exp_t q[$];
  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int kind, input logic [DW-1:0] d);
    exp_t e;
    e.kind = kind; e.data = d;
    q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [DW-1:0] d);
    exp_t e;
    if (q.size() == 0) begin
      check("unexpected_event", kind, 0);
    end else begin
      e = q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == K_DATA) check("data_o", d, e.data);
    end
  endtask

  // Scoreboard monitor: accepts, error pulses and overrun pulses each pop one entry,
  // so a pulse wider than one cycle shows up as an unexpected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx.valid_o && rx.ready_i) pop_check(K_DATA, rx.data_o);
      if (rx.frame_err_o)           pop_check(K_ERR, '0);
      if (rx.overrun_o)             pop_check(K_OVR, '0);
    end
  end

  // One SPI frame at sclk = clk/10; miso is sampled just before each rising edge.
  task automatic send(input logic [127:0] d, input int nbits, input bit finish, input int gap);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = d[i];
      repeat (5) @(negedge clk);
      if (i < DW) miso_cap[i] = miso;
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    if (finish) begin
      repeat (5) @(negedge clk);
      ss_n = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  logic [127:0] g, a5, fa, fb;

  initial begin
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rx.ready_i = 1'b1; tx_data = 96'h3; miso_cap = '0;
    repeat (3) @(negedge clk);
    check("rst_data", rx.data_o, 0);
    check("rst_valid", rx.valid_o, 0);
    check("rst_err", rx.frame_err_o, 0);
    check("rst_ovr", rx.overrun_o, 0);
    check("rst_miso", miso, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good frame
    g = 128'h0123_4567_89AB_CDEF_0011_2233;
    push(K_DATA, g[DW-1:0]);
    send(g, DW, 1, 10);
    check("good_q_empty", q.size(), 0);
    check("good_valid_cleared", rx.valid_o, 0);
    check("good_data_held", rx.data_o, g);

    // Short frame (95 bits)
    push(K_ERR, '0);
    send(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 95, 1, 10);
    check("short_q_empty", q.size(), 0);
    check("short_valid", rx.valid_o, 0);
    check("short_data_kept", rx.data_o, g);

    // Long frame (97 bits)
    push(K_ERR, '0);
    send(128'h1_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 97, 1, 10);
    check("long_q_empty", q.size(), 0);
    check("long_data_kept", rx.data_o, g);

    // Zero-length frame
    push(K_ERR, '0);
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check("zero_q_empty", q.size(), 0);

    // Overrun
    rx.ready_i = 1'b0;
    fa = 128'h1; fb = 128'h2;
    send(fa, DW, 1, 10);
    check("ovr_a_valid", rx.valid_o, 1);
    check("ovr_a_data", rx.data_o, fa);
    push(K_OVR, '0);
    send(fb, DW, 1, 10);
    check("ovr_q_empty", q.size(), 0);
    check("ovr_data_kept", rx.data_o, fa);
    check("ovr_valid_kept", rx.valid_o, 1);
    push(K_DATA, fa[DW-1:0]);
    rx.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("ovr_drain_valid", rx.valid_o, 0);
    check("ovr_drain_q", q.size(), 0);

    // Back-to-back with a 3-cycle ss_n high gap
    a5 = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    g  = 128'h5555_5555_5555_5555_5555_5555;
    push(K_DATA, a5[DW-1:0]);
    push(K_DATA, g[DW-1:0]);
    send(a5, DW, 1, 3);
    send(g, DW, 1, 10);
    check("b2b_q_empty", q.size(), 0);
    check("b2b_last_data", rx.data_o, g);

    // Reset mid-frame: ss_n released while rst is still high, so no error
    send(128'hFFFF_FFFF_FF, 40, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data", rx.data_o, 0);
    check("midrst_valid", rx.valid_o, 0);
    check("midrst_err", rx.frame_err_o, 0);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_event", q.size(), 0);

    rx.ready_i = 1'b0;
    miso_cap = '1;
    g = 128'hDEAD_BEEF;
    send(g, DW, 1, 10);
    check("deadbeef_data", rx.data_o, g);
    check("deadbeef_valid", rx.valid_o, 1);
`ifdef SPI_SLAVE_RX_MISO_EN
    check("miso_seq", miso_cap, 96'h3);
`else
    check("miso_low", miso_cap, 0);
`endif
    push(K_DATA, g[DW-1:0]);
    rx.ready_i = 1'b1;
    repeat (4) @(negedge clk);
    check("final_q_empty", q.size(), 0);
    check("final_valid", rx.valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI slave receiver, the far end of the team's TRNG SPI master link.
- Oversamples sclk/ss_n/mosi in the local clk domain and captures one DATA_WIDTH-bit frame per ss_n-low window, LSB first, on sclk rising edges.
- Presents each complete frame on a registered valid/ready output port.
- Flags short, long, and overrun frames.

Parameters:
- DATA_WIDTH, 96, frame length in bits (must be >= 2).
- SYNC_STAGES, 2, synchronizer flops per async input (must be >= 2).

Ports:
- clk  in  1  system clock; must be >= 4x sclk frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master, idle low (async).
- ss_n  in  1  slave select, active low (async).
- mosi  in  1  serial data from master (async).
- miso  out  1  serial data to master (see Optional Feature).
- tx_data_i  in  DATA_WIDTH  response word; used only with SPI_SLAVE_RX_MISO_EN.
- data_o  out  DATA_WIDTH  last good frame; bit 0 = first bit received.
- valid_o  out  1  data_o holds an unconsumed frame.
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i.
- frame_err_o  out  1  one-cycle pulse: frame ended with bit count != DATA_WIDTH.
- overrun_o  out  1  one-cycle pulse: good frame dropped because the previous one was unconsumed.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything:
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, miso=0.
  - FSM goes to IDLE; bit counter=0; shift register=0.
  - Synchronizers are preset to sclk=0, ss_n=1, mosi=0.
  - Reset mid-frame drops the frame with no error pulse. A frame still in progress when reset releases is received from its remaining bits, so it ends short and raises frame_err_o.
- Synchronizers: each input passes through SYNC_STAGES flops. Edges are detected by comparing the last stage with a one-cycle-delayed copy.
- FSM states are IDLE, RECV, CHECK.
  - IDLE: if synced ss_n==0 (level, not edge), go to RECV. On that transition, clear the bit counter and shift register and clear the too_long flag.
  - RECV, on a synced sclk rising edge:
    - If cnt < DATA_WIDTH: shreg[cnt] <= synced mosi; cnt <= cnt+1.
    - Otherwise set too_long.
    - Rising edges outside RECV are ignored.
  - RECV: synced ss_n==1 moves to CHECK. If an sclk edge and ss_n rise are detected in the same cycle, the edge is processed first.
  - CHECK lasts one cycle, then goes to IDLE.
    - Good frame: cnt==DATA_WIDTH and !too_long.
    - Good frame and (!valid_o or ready_i): data_o <= shreg; valid_o <= 1.
    - Good frame and valid_o & !ready_i: data_o unchanged; overrun_o pulses.
    - Bad frame: frame_err_o pulses; data_o/valid_o unchanged.
- Handshake:
  - valid_o stays high until a cycle with valid_o & ready_i, then clears next cycle.
  - If that accept cycle coincides with a CHECK load, the new frame loads and valid_o stays 1.
  - data_o is stable while valid_o=1 and not accepted.
- Latency: valid_o rises SYNC_STAGES+2 clk cycles after the ss_n rise is present at the pin at a clk edge.
- Zero-length frame (ss_n low, no sclk) gives frame_err_o. ss_n glitches shorter than one clk may be missed.
- Back-to-back frames: ss_n may fall again during CHECK; IDLE then sees the low level and enters RECV on the next cycle.
- Counter width is $clog2(DATA_WIDTH+1); it saturates at DATA_WIDTH.

Optional Feature:
- Macro: SPI_SLAVE_RX_MISO_EN.
- Defined:
  - On entry to RECV, txreg <= tx_data_i and miso = txreg[0].
  - On each synced sclk falling edge in RECV, the tx index advances and miso = txreg[index], LSB first.
  - After DATA_WIDTH bits, miso holds 0. In IDLE and CHECK, miso=0.
- Undefined: miso is tied to 0, tx_data_i is unused, and no txreg is built.

Test Plan:
- Good frame: master sends 96'h0123_4567_89AB_CDEF_0011_2233 at sclk=clk/10 with ready_i=1 -> data_o equals that value, valid_o high for 1 cycle, no error pulses.
- Short frame: 95 sclk rising edges then ss_n high -> frame_err_o=1 for exactly one cycle; valid_o=0; data_o keeps its prior value.
- Long frame: 97 rising edges -> frame_err_o pulses; data_o unchanged.
- Overrun: frame A=96'h1 accepted into data_o with ready_i=0, then frame B=96'h2 -> overrun_o pulses; data_o stays 96'h1. Raising ready_i then clears valid_o.
- Back-to-back: ss_n high for only 3 clk between two frames (96'hAAAA… then 96'h5555…) -> both frames delivered in order, no errors.
- Reset mid-frame: rst asserted after 40 bits, released, then a clean frame 96'hDEAD_BEEF -> outputs 0 during reset, then data_o=96'hDEAD_BEEF with valid_o=1. With SPI_SLAVE_RX_MISO_EN and tx_data_i=96'h3, miso reads 1,1,0,… on successive sclk falls.
